// File: rtl/faultify_cut_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : faultify_cut_harness                                            |
// | Brief    : Fault-injection wrapper between the Faultify register bank and  |
// |            an instrumented CUT: mask load, timed injection window, golden  |
// |            compare. Optional FAULTIFY_HARNESS_TIMESTAMP_EN enables the     |
// |            first-mismatch timestamp (tied to 0 when undefined).            |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module faultify_cut_harness #(
    parameter int TV_WIDTH   = 32,
    parameter int RV_WIDTH   = 54,
    parameter int INJ_WIDTH  = 216,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TV_WIDTH-1:0]   test_vector,
    output logic [TV_WIDTH-1:0]   cut_test_vector,
    input  logic [RV_WIDTH-1:0]   cut_result,
    input  logic [RV_WIDTH-1:0]   golden_result,
    output logic [INJ_WIDTH-1:0]  cut_injection,
    input  logic                  mask_valid,
    output logic                  mask_ready,
    input  logic [WORD_WIDTH-1:0] mask_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  delay_cycles,
    input  logic [CNT_WIDTH-1:0]  inject_cycles,
    input  logic [CNT_WIDTH-1:0]  observe_cycles,
    output logic                  busy,
    output logic                  done,
    output logic                  mask_loaded,
    output logic                  error_detected,
    output logic [CNT_WIDTH-1:0]  first_err_cycle,
    output logic [RV_WIDTH-1:0]   result_capture
);

    localparam int c_NWORDS = (INJ_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int c_IDX_W  = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(c_NWORDS - 1);
    localparam logic [CNT_WIDTH-1:0] c_ONE      = CNT_WIDTH'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_DELAY   = 3'd1;
    localparam logic [2:0] c_ST_INJECT  = 3'd2;
    localparam logic [2:0] c_ST_OBSERVE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]           r_state, w_nextState;
    logic [CNT_WIDTH-1:0] r_cnt, w_nextCnt;
    logic [CNT_WIDTH-1:0] r_injLen, r_obsLen;
    logic [INJ_WIDTH-1:0] r_mask;
    logic [c_IDX_W-1:0]   r_wordIdx;
    logic                 r_maskLoaded;
    logic                 r_err;
    logic [INJ_WIDTH-1:0] r_inj;
    logic [RV_WIDTH-1:0]  r_capture;
    logic                 w_idle, w_startAcc, w_compare, w_mismatch, w_maskWr;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_startAcc = w_idle && start && !abort;
    assign w_compare  = (r_state == c_ST_INJECT) || (r_state == c_ST_OBSERVE);
    assign w_mismatch = w_compare && (cut_result != golden_result);
    assign w_maskWr   = mask_valid && w_idle;

    // Zero-length phases are skipped, so every transition looks ahead to the next non-zero phase.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        if (abort) begin
            w_nextState = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (delay_cycles != '0) begin
                            w_nextState = c_ST_DELAY;
                            w_nextCnt   = delay_cycles - c_ONE;
                        end else if (inject_cycles != '0) begin
                            w_nextState = c_ST_INJECT;
                            w_nextCnt   = inject_cycles - c_ONE;
                        end else if (observe_cycles != '0) begin
                            w_nextState = c_ST_OBSERVE;
                            w_nextCnt   = observe_cycles - c_ONE;
                        end else begin
                            w_nextState = c_ST_DONE;
                            w_nextCnt   = '0;
                        end
                    end
                end
                c_ST_DELAY: begin
                    if (r_cnt != '0) begin
                        w_nextCnt = r_cnt - c_ONE;
                    end else if (r_injLen != '0) begin
                        w_nextState = c_ST_INJECT;
                        w_nextCnt   = r_injLen - c_ONE;
                    end else if (r_obsLen != '0) begin
                        w_nextState = c_ST_OBSERVE;
                        w_nextCnt   = r_obsLen - c_ONE;
                    end else begin
                        w_nextState = c_ST_DONE;
                    end
                end
                c_ST_INJECT: begin
                    if (r_cnt != '0) begin
                        w_nextCnt = r_cnt - c_ONE;
                    end else if (r_obsLen != '0) begin
                        w_nextState = c_ST_OBSERVE;
                        w_nextCnt   = r_obsLen - c_ONE;
                    end else begin
                        w_nextState = c_ST_DONE;
                    end
                end
                c_ST_OBSERVE: begin
                    if (r_cnt != '0) begin
                        w_nextCnt = r_cnt - c_ONE;
                    end else begin
                        w_nextState = c_ST_DONE;
                    end
                end
                default: begin
                    w_nextState = c_ST_IDLE;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_injLen     <= '0;
            r_obsLen     <= '0;
            r_mask       <= '0;
            r_wordIdx    <= '0;
            r_maskLoaded <= 1'b0;
            r_err        <= 1'b0;
            r_inj        <= '0;
            r_capture    <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            // Injection is registered off the next state so it aligns exactly with INJECT.
            r_inj   <= (w_nextState == c_ST_INJECT) ? r_mask : '0;
            if (w_startAcc) begin
                r_injLen <= inject_cycles;
                r_obsLen <= observe_cycles;
                r_err    <= 1'b0;
            end
            if (w_compare) begin
                r_capture <= cut_result;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
            if (w_maskWr) begin
                for (int i = 0; i < INJ_WIDTH; i++) begin
                    if (r_wordIdx == c_IDX_W'(i / WORD_WIDTH)) begin
                        r_mask[i] <= mask_data[i % WORD_WIDTH];
                    end
                end
                if (r_wordIdx == c_LAST_IDX) begin
                    r_wordIdx    <= '0;
                    r_maskLoaded <= 1'b1;
                end else begin
                    r_wordIdx <= r_wordIdx + 1'b1;
                end
            end
        end
    end

`ifdef FAULTIFY_HARNESS_TIMESTAMP_EN
    logic [CNT_WIDTH-1:0] r_offset;
    logic [CNT_WIDTH-1:0] r_firstErr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_offset   <= '0;
            r_firstErr <= '0;
        end else if (w_startAcc) begin
            r_offset   <= '0;
            r_firstErr <= '0;
        end else if (w_compare) begin
            if (w_mismatch && !r_err) begin
                r_firstErr <= r_offset;
            end
            if (r_offset != '1) begin
                r_offset <= r_offset + c_ONE;
            end
        end
    end

    assign first_err_cycle = r_firstErr;
`else
    assign first_err_cycle = '0;
`endif

    assign cut_test_vector = test_vector;
    assign cut_injection   = r_inj;
    assign mask_ready      = w_idle;
    assign busy            = !w_idle;
    assign done            = (r_state == c_ST_DONE);
    assign mask_loaded     = r_maskLoaded;
    assign error_detected  = r_err;
    assign result_capture  = r_capture;

endmodule
`default_nettype wire

// File: tb/tb_faultify_cut_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_faultify_cut_harness                                         |
// | Brief    : Randomised scoreboard bench for faultify_cut_harness.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_faultify_cut_harness;

    localparam int TV  = 32;
    localparam int RV  = 54;
    localparam int INJ = 216;
    localparam int W   = 32;
    localparam int CW  = 16;
    localparam int NW  = 7;

    logic            clk;
    logic            rst;
    logic [TV-1:0]   test_vector, cut_test_vector;
    logic [RV-1:0]   cut_result, golden_result, result_capture;
    logic [INJ-1:0]  cut_injection;
    logic            mask_valid, mask_ready;
    logic [W-1:0]    mask_data;
    logic            start, abort;
    logic [CW-1:0]   delay_cycles, inject_cycles, observe_cycles, first_err_cycle;
    logic            busy, done, mask_loaded, error_detected;

    faultify_cut_harness dut (
        .clk(clk), .rst(rst),
        .test_vector(test_vector), .cut_test_vector(cut_test_vector),
        .cut_result(cut_result), .golden_result(golden_result),
        .cut_injection(cut_injection),
        .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_data(mask_data),
        .start(start), .abort(abort),
        .delay_cycles(delay_cycles), .inject_cycles(inject_cycles), .observe_cycles(observe_cycles),
        .busy(busy), .done(done), .mask_loaded(mask_loaded),
        .error_detected(error_detected), .first_err_cycle(first_err_cycle),
        .result_capture(result_capture)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            runLen;
        int            injLen;
        bit            err;
        logic [CW-1:0] first;
        logic [RV-1:0] cap;
    } exp_t;

    exp_t             q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [NW*W-1:0]  shadow   = '0;
    int               wordIdx  = 0;
    bit               expLoaded = 1'b0;
    logic [INJ-1:0]   expMask  = '0;
    logic [RV-1:0]    prevCap  = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        shadow    = '0;
        wordIdx   = 0;
        expLoaded = 1'b0;
        expMask   = '0;
        prevCap   = '0;
    endfunction

    task automatic loadWord(input logic [W-1:0] w);
        @(negedge clk);
        mask_valid = 1'b1;
        mask_data  = w;
        @(negedge clk);
        mask_valid = 1'b0;
        shadow[wordIdx*W +: W] = w;
        wordIdx = (wordIdx + 1) % NW;
        if (wordIdx == 0) expLoaded = 1'b1;
        expMask = shadow[INJ-1:0];
        chk("mask_loaded", mask_loaded, expLoaded);
    endtask

    // stopKind: 0 = run to completion, 1 = abort at cycle stopAt, 2 = reset at cycle stopAt.
    // mode: 0 never mismatch, 1 always, 2 only at offset fixedOff, 3 random.
    task automatic doRun(input int d, input int n, input int o, input int mode, input int fixedOff,
                         input int stopKind, input int stopAt, input bit disturb);
        logic [RV-1:0] g, cap, diff;
        logic [RV-1:0] res [0:63];
        exp_t          e;
        int            L, lim, off, firstOff;
        bit            errSeen, mm;
        L        = d + n + o + 1;
        lim      = (stopKind != 0) ? stopAt : L - 1;
        g        = RV'({$urandom, $urandom});
        errSeen  = 1'b0;
        firstOff = 0;
        cap      = prevCap;
        for (int k = 1; k <= L; k++) begin
            res[k] = RV'({$urandom, $urandom});
            if (k > d && k <= d + n + o) begin
                off = k - d - 1;
                case (mode)
                    0:       mm = 1'b0;
                    1:       mm = 1'b1;
                    2:       mm = (off == fixedOff);
                    default: mm = ($urandom_range(0, 3) == 0);
                endcase
                diff   = RV'({$urandom, $urandom}) | (RV'(1) << $urandom_range(0, RV - 1));
                res[k] = mm ? (g ^ diff) : g;
                if (k <= lim) begin
                    if (mm && !errSeen) begin
                        errSeen  = 1'b1;
                        firstOff = off;
                    end
                    cap = res[k];
                end
            end
        end
        e.runLen = L;
        e.injLen = n;
        e.err    = errSeen;
`ifdef FAULTIFY_HARNESS_TIMESTAMP_EN
        e.first  = CW'(firstOff);
`else
        e.first  = '0;
`endif
        e.cap    = cap;

        @(negedge clk);
        delay_cycles   = CW'(d);
        inject_cycles  = CW'(n);
        observe_cycles = CW'(o);
        golden_result  = g;
        cut_result     = RV'({$urandom, $urandom});
        test_vector    = $urandom;
        start          = 1'b1;
        if (stopKind == 0) q.push_back(e);
        #1 chk("tv_passthrough", cut_test_vector, test_vector);

        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            start      = 1'b0;
            cut_result = res[k];
            if (disturb && k == 1) begin
                start          = 1'b1;
                delay_cycles   = CW'($urandom_range(0, 9));
                inject_cycles  = CW'($urandom_range(0, 9));
                observe_cycles = CW'($urandom_range(0, 9));
                mask_valid     = 1'b1;
                mask_data      = $urandom;
            end
            if (k == 2) mask_valid = 1'b0;
            if (stopKind == 1 && k == stopAt) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", busy, 1'b0);
                chk("abort_injection", cut_injection, '0);
                chk("abort_done", done, 1'b0);
                chk("abort_error_kept", error_detected, errSeen);
                chk("abort_capture_kept", result_capture, cap);
                prevCap = cap;
                break;
            end
            if (stopKind == 2 && k == stopAt) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_mask_loaded", mask_loaded, 1'b0);
                chk("rst_error", error_detected, 1'b0);
                chk("rst_first_err", first_err_cycle, '0);
                chk("rst_injection", cut_injection, '0);
                chk("rst_capture", result_capture, '0);
                chk("rst_mask_ready", mask_ready, 1'b1);
                modelReset();
                @(negedge clk);
                rst = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        mask_valid = 1'b0;
        if (stopKind == 0) prevCap = cap;
    endtask

    // Monitor: counts busy and injection cycles, scores each completed run on its done pulse.
    initial begin
        int   busyCnt;
        int   injCnt;
        exp_t e;
        busyCnt = 0;
        injCnt  = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busyCnt++;
                if (cut_injection != '0) begin
                    injCnt++;
                    chk("inj_value", cut_injection, expMask);
                end
            end
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("run_len", busyCnt, e.runLen);
                    chk("inj_cycles", injCnt, e.injLen);
                    chk("error_detected", error_detected, e.err);
                    chk("first_err_cycle", first_err_cycle, e.first);
                    chk("result_capture", result_capture, e.cap);
                end
            end
            if (busy !== 1'b1) begin
                busyCnt = 0;
                injCnt  = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b0;
        test_vector    = '0;
        cut_result     = '0;
        golden_result  = '0;
        mask_valid     = 1'b0;
        mask_data      = '0;
        start          = 1'b0;
        abort          = 1'b0;
        delay_cycles   = '0;
        inject_cycles  = '0;
        observe_cycles = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_mask_ready", mask_ready, 1'b1);
        chk("reset_mask_loaded", mask_loaded, 1'b0);
        chk("reset_error", error_detected, 1'b0);
        chk("reset_first_err", first_err_cycle, '0);
        chk("reset_injection", cut_injection, '0);
        chk("reset_capture", result_capture, '0);
        rst = 1'b1;

        for (int i = 0; i < NW; i++) loadWord(32'hFFFF_FFFF);
        chk("idle_injection", cut_injection, '0);

        doRun(3, 2, 4, 1, 0, 0, 0, 1'b0);
        doRun(0, 0, 0, 1, 0, 0, 0, 1'b0);
        doRun(0, 3, 4, 2, 4, 0, 0, 1'b0);
        doRun(2, 2, 2, 0, 0, 0, 0, 1'b0);
        doRun(1, 10, 2, 0, 0, 1, 3, 1'b0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", busy, 1'b0);

        for (int i = 0; i < 10; i++) loadWord($urandom);
        for (int r = 0; r < 25; r++) begin
            doRun($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                  3, 0, 0, 0, 1'($urandom_range(0, 1)));
        end

        doRun(0, 1, 5, 1, 0, 2, 3, 1'b0);
        for (int i = 0; i < NW; i++) loadWord($urandom);
        doRun(1, 2, 1, 3, 0, 0, 0, 1'b0);
        doRun(0, 2, 0, 1, 0, 0, 0, 1'b0);

        repeat (5) @(negedge clk);
        chk("pending_done", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
